// File: rtl/key_scheduler.sv
// key_scheduler: routes PS/2 key pulses by game state; play-mode arrows are
// queued in a small FIFO and released to the move unit at a fixed step rate.
module key_scheduler #(
  parameter int DEPTH       = 4,
  parameter int STEP_CYCLES = 5_000_000
) (
  input  logic                   clk,
  input  logic                   rst_sys,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   enter,
  input  logic [1:0]             state,
  input  logic                   arrived,
  output logic                   sel_up,
  output logic                   sel_down,
  output logic                   sel_left,
  output logic                   sel_right,
  output logic                   mv_up,
  output logic                   mv_down,
  output logic                   mv_left,
  output logic                   mv_right,
  output logic                   enter_o,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL   = CW'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    mv_q, mv_d;
  logic          enter_q, enter_d;

  logic       arrow_vld;
  logic [1:0] arrow_code;
  logic       flush;
  logic       pop;
  logic       push;

  // Direction codes: up=0 down=1 left=2 right=3; lower code wins on collisions.
  always_comb begin
    arrow_vld = up | down | left | right;
    if (up)        arrow_code = 2'd0;
    else if (down) arrow_code = 2'd1;
    else if (left) arrow_code = 2'd2;
    else           arrow_code = 2'd3;
  end

  assign flush = (state != 2'b01) || arrived;
  assign pop   = !flush && (timer_q == '0) && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = !flush && arrow_vld && ((count_q != COUNT_FULL) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;
    ovf_d    = ovf_q;
    sel_d    = '0;
    mv_d     = '0;
    enter_d  = enter;

    if (state == 2'b00 && arrow_vld) sel_d[arrow_code] = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      timer_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        mv_d[mem_q[rd_ptr_q]] = 1'b1;
        rd_ptr_d              = rd_ptr_q + PW'(1);
        timer_d               = TIMER_RELOAD;
      end else if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (arrow_vld && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      sel_q    <= '0;
      mv_q     <= '0;
      enter_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= arrow_code;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      sel_q    <= sel_d;
      mv_q     <= mv_d;
      enter_q  <= enter_d;
    end
  end

  assign sel_up     = sel_q[0];
  assign sel_down   = sel_q[1];
  assign sel_left   = sel_q[2];
  assign sel_right  = sel_q[3];
  assign mv_up      = mv_q[0];
  assign mv_down    = mv_q[1];
  assign mv_left    = mv_q[2];
  assign mv_right   = mv_q[3];
  assign enter_o    = enter_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
